// File: rtl/bus_endpoint_pkg.sv
// Shared definitions for bus endpoint devices.
// Used by the endpoint, its FIFOs and the device benches.
package bus_endpoint_pkg;
   localparam int CNT_W    = 16;
   localparam int BITS_DEF = 32;
   localparam int ID_W_DEF = 8;

   localparam logic [ID_W_DEF-1:0] BROADCAST_DEF = 8'hFF;

   function automatic logic [ID_W_DEF-1:0] dest_of(
      input logic [BITS_DEF-1:0] word
   );
      return word[BITS_DEF-1 -: ID_W_DEF];
   endfunction
endpackage

// File: rtl/endpoint_fifo.sv
// First-word-fall-through FIFO with separate occupancy count.
// Writes when full and reads when empty are ignored internally.
module endpoint_fifo #(
   parameter  int BITS  = 32,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [BITS-1:0] wr_data,
   input  logic            rd_en,
   output logic [BITS-1:0] rd_data,
   output logic            full,
   output logic            empty,
   output logic [LW-1:0]   level
);
   logic [BITS-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [LW-1:0]   cnt;
   logic            do_wr;
   logic            do_rd;

   assign full    = (cnt == LW'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign rd_data = mem[rptr];

   // fullness is taken before any same-cycle read: no bypass
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_wr) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + 1'b1;
         end
         if (do_rd) begin
            rptr <= rptr + 1'b1;
         end
         if (do_wr && !do_rd) begin
            cnt <= cnt + 1'b1;
         end else if (do_rd && !do_wr) begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_endpoint.sv
// Device-side bus endpoint: TX/RX FIFOs, destination filter
// and saturating drop counters.
module bus_endpoint
   import bus_endpoint_pkg::*;
#(
   parameter  int              BITS      = 32,
   parameter  int              ID_W      = 8,
   parameter  int              DEPTH     = 8,
   parameter  logic [ID_W-1:0] MY_ID     = '0,
   parameter  logic [ID_W-1:0] BROADCAST = ID_W'(BROADCAST_DEF),
   localparam int              LW        = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_valid,
   input  logic [BITS-1:0]  tx_data,
   output logic             tx_ready,
   output logic             pndng,
   output logic [BITS-1:0]  D_pop,
   input  logic             pop,
   input  logic             push,
   input  logic [BITS-1:0]  D_push,
   output logic             rx_valid,
   output logic [BITS-1:0]  rx_data,
   input  logic             rx_ready,
   output logic [LW-1:0]    tx_level,
   output logic [LW-1:0]    rx_level,
   output logic [CNT_W-1:0] drop_addr_cnt,
   output logic [CNT_W-1:0] drop_full_cnt
);
   logic            tx_full;
   logic            tx_empty;
   logic            rx_full;
   logic            rx_empty;
   logic [ID_W-1:0] dest;
   logic            hit;

   assign dest     = D_push[BITS-1 -: ID_W];
   assign hit      = (dest == MY_ID) || (dest == BROADCAST);
   assign tx_ready = !tx_full;
   assign pndng    = !tx_empty;
   assign rx_valid = !rx_empty;

   endpoint_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_tx (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (tx_valid),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (D_pop),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (tx_level)
   );

   endpoint_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_rx (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (push && hit),
      .wr_data (D_push),
      .rd_en   (rx_ready),
      .rd_data (rx_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .level   (rx_level)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_addr_cnt <= '0;
         drop_full_cnt <= '0;
      end else if (push) begin
         if (!hit) begin
            if (drop_addr_cnt != '1) begin
               drop_addr_cnt <= drop_addr_cnt + 1'b1;
            end
         end else if (rx_full) begin
            if (drop_full_cnt != '1) begin
               drop_full_cnt <= drop_full_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_bus_endpoint.sv
// Directed bench for bus_endpoint with DEPTH=8, MY_ID=2.
// One task per scenario, inline comparisons.
module tb_bus_endpoint;
   import bus_endpoint_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tx_valid = 1'b0;
   logic [31:0] tx_data = '0;
   logic        tx_ready;
   logic        pndng;
   logic [31:0] D_pop;
   logic        pop = 1'b0;
   logic        push = 1'b0;
   logic [31:0] D_push = '0;
   logic        rx_valid;
   logic [31:0] rx_data;
   logic        rx_ready = 1'b0;
   logic [3:0]  tx_level;
   logic [3:0]  rx_level;
   logic [15:0] drop_addr_cnt;
   logic [15:0] drop_full_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   bus_endpoint #(
      .BITS(32), .ID_W(8), .DEPTH(8), .MY_ID(8'd2), .BROADCAST(8'hFF)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_level(tx_level), .rx_level(rx_level),
      .drop_addr_cnt(drop_addr_cnt), .drop_full_cnt(drop_full_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) step();
      reset = 1'b1;
      step();
      tx_valid = 1'b1;
      tx_data  = 32'h1111_0001;
      push     = 1'b1;
      D_push   = 32'h0200_0055;
      step();
      push     = 1'b0;
      step();
      tx_valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({pndng, rx_valid, tx_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL rst_flags got %b want 001",
                  {pndng, rx_valid, tx_ready});
      end
      n_cmp++;
      if ({tx_level, rx_level} !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_levels got %h want 00", {tx_level, rx_level});
      end
      n_cmp++;
      if ({drop_addr_cnt, drop_full_cnt} !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_cnts got %h want 0",
                  {drop_addr_cnt, drop_full_cnt});
      end
      n_cmp++;
      if ({D_pop, rx_data} !== 64'h0) begin
         n_bad++;
         $display("FAIL rst_data got %h %h want 0", D_pop, rx_data);
      end
      #2;
      reset = 1'b1;
      step();
   endtask

   task automatic test_tx_fill();
      for (int i = 1; i <= 8; i++) begin
         tx_valid = 1'b1;
         tx_data  = 32'h0200_0000 + i;
         step();
         n_cmp++;
         if (tx_level !== 4'(i)) begin
            n_bad++;
            $display("FAIL tx_fill_lvl got %0d want %0d", tx_level, i);
         end
      end
      n_cmp++;
      if (tx_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_ready_full got %b want 0", tx_ready);
      end
      tx_data = 32'h0200_0009;
      step();
      tx_valid = 1'b0;
      n_cmp++;
      if (tx_level !== 4'd8) begin
         n_bad++;
         $display("FAIL tx_refuse got %0d want 8", tx_level);
      end
      for (int i = 1; i <= 8; i++) begin
         n_cmp++;
         if (D_pop !== 32'h0200_0000 + i) begin
            n_bad++;
            $display("FAIL tx_order got %h want %h", D_pop,
                     32'h0200_0000 + i);
         end
         pop = 1'b1;
         step();
      end
      pop = 1'b0;
      n_cmp++;
      if (pndng !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_pndng_empty got %b want 0", pndng);
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
      n_cmp++;
      if (tx_level !== 4'd0) begin
         n_bad++;
         $display("FAIL tx_pop_empty got %0d want 0", tx_level);
      end
   endtask

   task automatic test_rx_filter();
      push   = 1'b1;
      D_push = 32'h0200_00AA;
      step();
      push = 1'b0;
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 32'h0200_00AA}) begin
         n_bad++;
         $display("FAIL rx_accept got %b %h want 1 020000aa",
                  rx_valid, rx_data);
      end
      push   = 1'b1;
      D_push = 32'h0300_00BB;
      step();
      push = 1'b0;
      n_cmp++;
      if (drop_addr_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL rx_addr_drop got %0d want 1", drop_addr_cnt);
      end
      push   = 1'b1;
      D_push = 32'hFF00_00CC;
      step();
      push = 1'b0;
      n_cmp++;
      if (rx_level !== 4'd2) begin
         n_bad++;
         $display("FAIL rx_bcast_lvl got %0d want 2", rx_level);
      end
      rx_ready = 1'b1;
      step();
      n_cmp++;
      if (rx_data !== 32'hFF00_00CC) begin
         n_bad++;
         $display("FAIL rx_bcast_data got %h want ff0000cc", rx_data);
      end
      step();
      rx_ready = 1'b0;
   endtask

   task automatic fill_rx(input logic [31:0] base);
      for (int i = 0; i < 8; i++) begin
         push   = 1'b1;
         D_push = base + i;
         step();
      end
      push = 1'b0;
   endtask

   task automatic test_rx_overflow();
      fill_rx(32'h0200_0010);
      for (int i = 0; i < 3; i++) begin
         push   = 1'b1;
         D_push = 32'h0200_0090 + i;
         step();
      end
      push = 1'b0;
      n_cmp++;
      if (drop_full_cnt !== 16'd3) begin
         n_bad++;
         $display("FAIL rx_full_drop got %0d want 3", drop_full_cnt);
      end
      n_cmp++;
      if (dest_of(32'h0200_0090) == 8'd2 && drop_addr_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL rx_full_addr got %0d want 1", drop_addr_cnt);
      end
      rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (rx_data !== 32'h0200_0010 + i) begin
            n_bad++;
            $display("FAIL rx_ovf_order got %h want %h", rx_data,
                     32'h0200_0010 + i);
         end
         step();
      end
      rx_ready = 1'b0;
      n_cmp++;
      if (rx_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rx_ovf_empty got %b want 0", rx_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rq[$];
      logic [31:0] tq[$];
      logic [31:0] nw;
      for (int k = 0; k < 3; k++) begin
         push     = 1'b1;
         D_push   = 32'h0200_1000 + k;
         tx_valid = 1'b1;
         tx_data  = 32'hA000_0000 + k;
         rq.push_back(D_push);
         tq.push_back(tx_data);
         step();
      end
      for (int c = 0; c < 100; c++) begin
         n_cmp++;
         if (rx_data !== rq[0] || rx_level !== 4'd3) begin
            n_bad++;
            $display("FAIL b2b_rx c=%0d got %h/%0d want %h/3", c,
                     rx_data, rx_level, rq[0]);
         end
         n_cmp++;
         if (D_pop !== tq[0] || tx_level !== 4'd3) begin
            n_bad++;
            $display("FAIL b2b_tx c=%0d got %h/%0d want %h/3", c,
                     D_pop, tx_level, tq[0]);
         end
         nw       = 32'h0200_2000 + c;
         D_push   = nw;
         rx_ready = 1'b1;
         tx_data  = 32'hB000_0000 + c;
         pop      = 1'b1;
         rq.push_back(nw);
         tq.push_back(tx_data);
         void'(rq.pop_front());
         void'(tq.pop_front());
         step();
      end
      push     = 1'b0;
      tx_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (rx_data !== rq[k] || D_pop !== tq[k]) begin
            n_bad++;
            $display("FAIL b2b_tail got %h %h want %h %h",
                     rx_data, D_pop, rq[k], tq[k]);
         end
         step();
      end
      rx_ready = 1'b0;
      pop      = 1'b0;
      n_cmp++;
      if ({drop_addr_cnt, drop_full_cnt} !== {16'd1, 16'd3}) begin
         n_bad++;
         $display("FAIL b2b_drops got %0d %0d want 1 3",
                  drop_addr_cnt, drop_full_cnt);
      end
      n_cmp++;
      if ({tx_level, rx_level} !== 8'h00) begin
         n_bad++;
         $display("FAIL b2b_levels got %h want 00", {tx_level, rx_level});
      end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 8; i++) begin
         tx_valid = 1'b1;
         tx_data  = 32'hC000_0000 + i;
         step();
      end
      tx_data = 32'hC000_00EE;
      pop     = 1'b1;
      step();
      tx_valid = 1'b0;
      pop      = 1'b0;
      n_cmp++;
      if (tx_level !== 4'd7 || D_pop !== 32'hC000_0001) begin
         n_bad++;
         $display("FAIL tx_full_simul got %0d %h want 7 c0000001",
                  tx_level, D_pop);
      end
      pop = 1'b1;
      for (int i = 1; i < 8; i++) begin
         step();
      end
      pop = 1'b0;
      n_cmp++;
      if (pndng !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_refused_word got pndng %b want 0", pndng);
      end
      fill_rx(32'h0200_0300);
      push     = 1'b1;
      D_push   = 32'h0200_03EE;
      rx_ready = 1'b1;
      step();
      push     = 1'b0;
      rx_ready = 1'b0;
      n_cmp++;
      if (rx_level !== 4'd7 || drop_full_cnt !== 16'd4) begin
         n_bad++;
         $display("FAIL rx_full_simul got %0d %0d want 7 4",
                  rx_level, drop_full_cnt);
      end
      n_cmp++;
      if (rx_data !== 32'h0200_0301) begin
         n_bad++;
         $display("FAIL rx_full_head got %h want 02000301", rx_data);
      end
   endtask

   initial begin
      test_reset();
      test_tx_fill();
      test_rx_filter();
      test_rx_overflow();
      test_back_to_back();
      test_full_simul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
